dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer for the single data memory. It shares the memory between the core load/store unit (port C) and an auxiliary master (port A), such as a program loader or a compliance-signature dump engine. It serialises requests through a small state machine, drives the memory's active-low chip-select and write strobes, and returns read data or a write acknowledge to the winning requester after a fixed, parameterised memory latency.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (mask width is `DATA_W/8`)
- `LAT`, 1, memory read latency in cycles from the chip-select cycle to valid `mem_rdata`; legal range 1..15

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `c_req`  in  1  core request; held with its fields until `c_gnt`
- `c_we`  in  1  1 = store, 0 = load
- `c_mask`  in  4  store byte enables
- `c_addr`  in  ADDR_W  byte address
- `c_wdata`  in  DATA_W  store data, already lane-aligned
- `c_gnt`  out  1  one-cycle pulse; request accepted
- `c_rvalid`  out  1  one-cycle pulse; load data valid or store completed
- `c_rdata`  out  DATA_W  load data, valid with `c_rvalid`
- `a_req`, `a_we`, `a_mask`, `a_addr`, `a_wdata`, `a_gnt`, `a_rvalid`, `a_rdata`: auxiliary port, identical semantics
- `mem_cs`  out  1  active-low chip select
- `mem_wr`  out  1  active-low write (0 = write, 1 = read)
- `mem_mask`  out  4  byte enables
- `mem_addr`  out  ADDR_W
- `mem_wdata`  out  DATA_W
- `mem_rdata`  in  DATA_W  valid exactly `LAT` cycles after the `mem_cs`=0 cycle

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If neither request is asserted, stay in IDLE.
  - If exactly one request is asserted, latch that port as `sel` and go to ISSUE.
  - If both are asserted, round-robin: pick the port not chosen last (`last_sel`), latch it, and go to ISSUE.
- ISSUE (1 cycle):
  - `mem_cs`=0.
  - `mem_wr`=~we of `sel`.
  - `mem_addr`/`mem_wdata` come from `sel`.
  - `mem_mask` = `sel` mask for stores, 4'b1111 for loads.
  - Pulse `sel` gnt; update `last_sel`=`sel`; load `cnt`=`LAT`; go to WAIT.
- WAIT:
  - `mem_cs`=1, `mem_wr`=1.
  - `cnt` decrements each cycle.
  - The cycle in which `cnt`==1 (i.e. `LAT` cycles after ISSUE): register `mem_rdata` (loads) or 0 (stores) into `rdata_q`, then go to RESP.
- RESP (1 cycle): pulse `sel` rvalid with rdata=`rdata_q`; return to IDLE.
- The non-selected port's gnt, rvalid and rdata are always 0.
- A request that is pending but not selected stays pending. The next IDLE visit grants it, so the worst-case wait is one transaction.
- Requester fields are sampled only in ISSUE. A request withdrawn between IDLE and ISSUE is a protocol violation; the transaction still issues.
- A store with mask 0 issues normally with `mem_mask`=0 and is acknowledged.
- `rdata` is 0 on all ports whenever rvalid=0.

## Timing
- Reset values:
  - State IDLE; `last_sel`=A, so the core wins the first contention.
  - `cnt`=0, `rdata_q`=0.
  - `mem_cs`=1, `mem_wr`=1; `mem_mask`, `mem_addr`, `mem_wdata` = 0.
  - All gnt, rvalid and rdata = 0.
- All outputs are decoded from registered state; no combinational path from `*_req` to `*_gnt`.
- Request seen in IDLE at cycle T gives:
  - gnt and `mem_cs`=0 at T+1;
  - `mem_rdata` sampled at T+1+`LAT`;
  - rvalid at T+2+`LAT`;
  - earliest next ISSUE at T+4+`LAT`.
- Throughput is one transaction per `LAT`+3 cycles.
- Reset asserted mid-transaction: all registers return to reset values immediately (asynchronously). The in-flight transaction is dropped with no rvalid. The requester must re-request.
- `LAT`=1: WAIT lasts exactly one cycle.

## Test plan
- Reset, then core load only. `c_req`=1, `c_we`=0, `c_addr`=0x100, memory returns 0xDEADBEEF, `LAT`=1. Expect:
  - `c_gnt` at T+1 with `mem_cs`=0, `mem_wr`=1, `mem_mask`=4'hF;
  - `c_rvalid`=1 with `c_rdata`=0xDEADBEEF at T+3;
  - `a_*` outputs stay 0.
- Aux store. `a_we`=1, `a_mask`=4'b0100, `a_wdata`=0x00AB0000, `a_addr`=0x204. Expect:
  - ISSUE drives `mem_wr`=0, `mem_mask`=4'b0100, `mem_wdata`=0x00AB0000;
  - `a_rvalid` pulses with `a_rdata`=0.
- Contention. `c_req` and `a_req` both held from reset. Expect grant order C, A, C, A, with gnt pulses spaced `LAT`+3 cycles apart.
- `LAT`=4, load. Expect:
  - `mem_cs` low for exactly 1 cycle;
  - `mem_rdata` sampled 4 cycles after ISSUE;
  - rvalid 5 cycles after ISSUE.
- Reset pulse during WAIT of a core load. Expect:
  - `mem_cs`=1 and all gnt, rvalid = 0 immediately;
  - no rvalid for the aborted load;
  - a held `c_req` is re-granted 2 cycles after reset release.
- Zero-mask store. `c_we`=1, `c_mask`=0. Expect `mem_cs`=0, `mem_wr`=0, `mem_mask`=0 in ISSUE, and `c_rvalid` acknowledge at T+2+`LAT`.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bus bundle between the data-memory arbiter, its two requesters
// (core port C, auxiliary port A) and the single data memory.
//   c_* / a_* : request (req, we, mask, addr, wdata) in,
//               response (gnt, rvalid, rdata) out
//   mem_*     : active-low cs/wr, byte mask, address, write data out,
//               read data in
// Modport "master" is the arbiter side; "slave" is the requesters plus
// the memory model.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    logic              c_req;
    logic              c_we;
    logic [MASK_W-1:0] c_mask;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              a_req;
    logic              a_we;
    logic [MASK_W-1:0] a_mask;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              mem_cs;
    logic              mem_wr;
    logic [MASK_W-1:0] mem_mask;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  c_req, c_we, c_mask, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  a_req, a_we, a_mask, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        output mem_cs, mem_wr, mem_mask, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        output c_req, c_we, c_mask, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output a_req, a_we, a_mask, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        input  mem_cs, mem_wr, mem_mask, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-port round-robin arbiter and sequencer for the single data memory.
// One transaction at a time: IDLE -> ISSUE (chip select, grant) ->
// WAIT (LAT cycles) -> RESP (rvalid + data) -> IDLE.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - dmem_arbiter_if.master (core port C, aux port A, memory side)
// Parameters: ADDR_W, DATA_W, LAT (1..15, chip-select to read-data cycles).
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_arbiter_if.master        bus
);
    localparam int MASK_W = DATA_W / 8;
    localparam logic SEL_C = 1'b0;
    localparam logic SEL_A = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e            state_r, state_nxt;
    logic              sel_r, sel_nxt;
    logic              last_sel_r, last_sel_nxt;
    logic              we_r, we_nxt;
    logic [3:0]        cnt_r, cnt_nxt;
    logic [DATA_W-1:0] rdata_q_r, rdata_q_nxt;

    // Fields of the selected requester; only consumed while in ISSUE.
    logic              sel_we_s;
    logic [MASK_W-1:0] sel_mask_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    // Route the selected port's request fields toward the memory.
    always_comb begin
        sel_we_s    = bus.c_we;
        sel_mask_s  = bus.c_mask;
        sel_addr_s  = bus.c_addr;
        sel_wdata_s = bus.c_wdata;
        if (sel_r == SEL_A) begin
            sel_we_s    = bus.a_we;
            sel_mask_s  = bus.a_mask;
            sel_addr_s  = bus.a_addr;
            sel_wdata_s = bus.a_wdata;
        end else begin
            sel_we_s    = bus.c_we;
            sel_mask_s  = bus.c_mask;
            sel_addr_s  = bus.c_addr;
            sel_wdata_s = bus.c_wdata;
        end
    end

    // Sequencer state registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            sel_r      <= SEL_C;
            last_sel_r <= SEL_A;      // core wins the first contention
            we_r       <= 1'b0;
            cnt_r      <= 4'd0;
            rdata_q_r  <= '0;
        end else begin
            state_r    <= state_nxt;
            sel_r      <= sel_nxt;
            last_sel_r <= last_sel_nxt;
            we_r       <= we_nxt;
            cnt_r      <= cnt_nxt;
            rdata_q_r  <= rdata_q_nxt;
        end
    end

    // Next-state logic: arbitration, latency countdown, read capture.
    always_comb begin
        state_nxt    = state_r;
        sel_nxt      = sel_r;
        last_sel_nxt = last_sel_r;
        we_nxt       = we_r;
        cnt_nxt      = cnt_r;
        rdata_q_nxt  = rdata_q_r;
        case (state_r)
            S_IDLE: begin
                if (bus.c_req && bus.a_req) begin
                    sel_nxt   = ~last_sel_r;
                    state_nxt = S_ISSUE;
                end else if (bus.c_req) begin
                    sel_nxt   = SEL_C;
                    state_nxt = S_ISSUE;
                end else if (bus.a_req) begin
                    sel_nxt   = SEL_A;
                    state_nxt = S_ISSUE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                // we is captured here so WAIT knows whether to keep mem_rdata.
                we_nxt       = sel_we_s;
                last_sel_nxt = sel_r;
                cnt_nxt      = 4'(LAT);
                state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                cnt_nxt = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    rdata_q_nxt = we_r ? {DATA_W{1'b0}} : bus.mem_rdata;
                    state_nxt   = S_RESP;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from registered state; requests never reach gnt directly.
    always_comb begin
        bus.mem_cs    = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_mask  = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.c_gnt     = 1'b0;
        bus.a_gnt     = 1'b0;
        bus.c_rvalid  = 1'b0;
        bus.a_rvalid  = 1'b0;
        bus.c_rdata   = '0;
        bus.a_rdata   = '0;
        case (state_r)
            S_ISSUE: begin
                bus.mem_cs    = 1'b0;
                bus.mem_wr    = ~sel_we_s;
                bus.mem_mask  = sel_we_s ? sel_mask_s : {MASK_W{1'b1}};
                bus.mem_addr  = sel_addr_s;
                bus.mem_wdata = sel_wdata_s;
                bus.c_gnt     = (sel_r == SEL_C);
                bus.a_gnt     = (sel_r == SEL_A);
            end
            S_RESP: begin
                if (sel_r == SEL_A) begin
                    bus.a_rvalid = 1'b1;
                    bus.a_rdata  = rdata_q_r;
                end else begin
                    bus.c_rvalid = 1'b1;
                    bus.c_rdata  = rdata_q_r;
                end
            end
            default: begin
                bus.mem_cs = 1'b1;
            end
        endcase
    end
endmodule
